present_inv_sbox_layer: RTL



---
 rtl/present_inv_sbox_layer.sv | 111 +++++++++++
 1 files changed

// File: rtl/present_inv_sbox_layer.sv
// PRESENT inverse S-box layer: replaces every nibble of the state with S^-1[nibble],
// one nibble per clock (LSB nibble first), through a single shared table lookup.
module present_inv_sbox_layer #(
  parameter int NIBBLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] state_in,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] state_out
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [W-1:0]   data_q, data_d;
  logic [3:0]     nib_in, nib_out;

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
    endcase
    return y;
  endfunction

  // The single shared lookup: select the current nibble, invert it.
  always_comb begin
    nib_in  = data_q[{cnt_q, 2'b00} +: 4];
    nib_out = inv_sbox(nib_in);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          data_d  = state_in;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        data_d[{cnt_q, 2'b00} +: 4] = nib_out;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(NIBBLES - 1)) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        // A start seen during the done cycle chains straight into the next job.
        if (start) begin
          data_d  = state_in;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      data_q  <= data_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign state_out = data_q;

endmodule
